clock_core_ctrl: RTL and testbench

- Time-base and counter controller for the digital clock.
- Consumes the debounced control strobes and mode from the key handler.
- Owns the time-of-day counters, the alarm registers and the stopwatch counters, and sequences which one the up/down/clear/pause controls act on.
- Outputs are binary fields for the display formatter and a ring request for the buzzer driver.

---
 rtl/clock_core_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_clock_core_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_core_ctrl.sv
// Digital clock core: 100 Hz / 1 Hz prescaler, time of day, alarm registers,
// stopwatch and the alarm ring sequencer. Outputs are binary display fields.
module clock_core_ctrl #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int RING_SECS    = 30,
  parameter int ALARM_INIT_H = 7,
  parameter int ALARM_INIT_M = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] model,
  input  logic [1:0] adjust_shif,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       pause,
  input  logic       clear,
  output logic [4:0] time_h,
  output logic [5:0] time_m,
  output logic [5:0] time_s,
  output logic [4:0] alarm_h,
  output logic [5:0] alarm_m,
  output logic       alarm_en,
  output logic [5:0] sw_m,
  output logic [5:0] sw_s,
  output logic [6:0] sw_cs,
  output logic       ring,
  output logic       tick_1s
);

  localparam int DIV = CLK_FREQ / 100;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST  = PW'(DIV - 1);
  localparam logic [5:0]    RING_LAST = 6'(RING_SECS - 1);
  localparam logic [4:0]    AL_H_INIT = 5'(ALARM_INIT_H);
  localparam logic [5:0]    AL_M_INIT = 6'(ALARM_INIT_M);

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'b00,
    MODE_ALARM = 2'b01,
    MODE_SW    = 2'b10,
    MODE_ADJ   = 2'b11
  } mode_e;

  mode_e         mode;
  logic [1:0]    fld;
  logic          step_up, step_dn, step_any, key_any;
  logic          tick_100, advance, alarm_hit;

  logic [PW-1:0] pre100_q, pre100_d;
  logic [6:0]    pre1s_q, pre1s_d;
  logic          tick_1s_q, tick_1s_d;
  logic [4:0]    time_h_q, time_h_d;
  logic [5:0]    time_m_q, time_m_d;
  logic [5:0]    time_s_q, time_s_d;
  logic [4:0]    alarm_h_q, alarm_h_d;
  logic [5:0]    alarm_m_q, alarm_m_d;
  logic          alarm_en_q, alarm_en_d;
  logic [5:0]    sw_m_q, sw_m_d;
  logic [5:0]    sw_s_q, sw_s_d;
  logic [6:0]    sw_cs_q, sw_cs_d;
  logic          ring_q, ring_d;
  logic [5:0]    ring_cnt_q, ring_cnt_d;

  // One step of a field that wraps between 0 and top in either direction.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                           input logic up);
    if (up) return (v == top) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  assign mode     = mode_e'(model);
  assign fld      = (adjust_shif == 2'b11) ? 2'b00 : adjust_shif;
  assign key_any  = key_up | key_down;
  assign step_up  = key_up & ~key_down;
  assign step_dn  = key_down & ~key_up;
  assign step_any = step_up | step_dn;
  assign advance  = tick_1s_q && (mode != MODE_ADJ);

  always_comb begin
    pre100_d  = pre100_q;
    pre1s_d   = pre1s_q;
    tick_1s_d = 1'b0;
    tick_100  = 1'b0;
    if (mode == MODE_ADJ) begin
      pre100_d = '0;
      pre1s_d  = '0;
    end else begin
      tick_100 = (pre100_q == DIV_LAST);
      pre100_d = tick_100 ? '0 : pre100_q + PW'(1);
      if (tick_100) begin
        tick_1s_d = (pre1s_q == 7'd99);
        pre1s_d   = (pre1s_q == 7'd99) ? 7'd0 : pre1s_q + 7'd1;
      end
    end
  end

  always_comb begin
    time_h_d = time_h_q;
    time_m_d = time_m_q;
    time_s_d = time_s_q;
    if (advance) begin
      if (time_s_q != 6'd59) begin
        time_s_d = time_s_q + 6'd1;
      end else begin
        time_s_d = 6'd0;
        if (time_m_q != 6'd59) begin
          time_m_d = time_m_q + 6'd1;
        end else begin
          time_m_d = 6'd0;
          time_h_d = (time_h_q == 5'd23) ? 5'd0 : time_h_q + 5'd1;
        end
      end
    end else if (mode == MODE_ADJ && step_any) begin
      case (fld)
        2'b01:   time_m_d = wrap_step(time_m_q, 6'd59, step_up);
        2'b10:   time_h_d = 5'(wrap_step({1'b0, time_h_q}, 6'd23, step_up));
        default: time_s_d = wrap_step(time_s_q, 6'd59, step_up);
      endcase
    end
  end

  always_comb begin
    alarm_h_d  = alarm_h_q;
    alarm_m_d  = alarm_m_q;
    alarm_en_d = alarm_en_q;
    if (mode == MODE_ALARM && step_any) begin
      case (fld)
        2'b01:   alarm_m_d = wrap_step(alarm_m_q, 6'd59, step_up);
        2'b10:   alarm_h_d = 5'(wrap_step({1'b0, alarm_h_q}, 6'd23, step_up));
        default: alarm_en_d = step_up;
      endcase
    end
  end

  // Only a real seconds update can start the ring; manual adjust never does.
  assign alarm_hit = advance && (time_s_d == 6'd0) && alarm_en_q &&
                     (time_h_d == alarm_h_q) && (time_m_d == alarm_m_q);

  always_comb begin
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    if (ring_q) begin
      if (advance) ring_cnt_d = ring_cnt_q + 6'd1;
      if (key_any || !alarm_en_d || (advance && ring_cnt_q == RING_LAST)) ring_d = 1'b0;
    end else if (alarm_hit && !key_any) begin
      ring_d     = 1'b1;
      ring_cnt_d = 6'd0;
    end
  end

  always_comb begin
    sw_m_d  = sw_m_q;
    sw_s_d  = sw_s_q;
    sw_cs_d = sw_cs_q;
    if (clear) begin
      sw_m_d  = 6'd0;
      sw_s_d  = 6'd0;
      sw_cs_d = 7'd0;
    end else if (tick_100 && pause) begin
      if (sw_cs_q != 7'd99) begin
        sw_cs_d = sw_cs_q + 7'd1;
      end else begin
        sw_cs_d = 7'd0;
        if (sw_s_q != 6'd59) begin
          sw_s_d = sw_s_q + 6'd1;
        end else begin
          sw_s_d = 6'd0;
          sw_m_d = (sw_m_q == 6'd59) ? 6'd0 : sw_m_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre100_q   <= '0;
      pre1s_q    <= '0;
      tick_1s_q  <= 1'b0;
      time_h_q   <= '0;
      time_m_q   <= '0;
      time_s_q   <= '0;
      alarm_h_q  <= AL_H_INIT;
      alarm_m_q  <= AL_M_INIT;
      alarm_en_q <= 1'b0;
      sw_m_q     <= '0;
      sw_s_q     <= '0;
      sw_cs_q    <= '0;
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      pre100_q   <= pre100_d;
      pre1s_q    <= pre1s_d;
      tick_1s_q  <= tick_1s_d;
      time_h_q   <= time_h_d;
      time_m_q   <= time_m_d;
      time_s_q   <= time_s_d;
      alarm_h_q  <= alarm_h_d;
      alarm_m_q  <= alarm_m_d;
      alarm_en_q <= alarm_en_d;
      sw_m_q     <= sw_m_d;
      sw_s_q     <= sw_s_d;
      sw_cs_q    <= sw_cs_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  assign time_h   = time_h_q;
  assign time_m   = time_m_q;
  assign time_s   = time_s_q;
  assign alarm_h  = alarm_h_q;
  assign alarm_m  = alarm_m_q;
  assign alarm_en = alarm_en_q;
  assign sw_m     = sw_m_q;
  assign sw_s     = sw_s_q;
  assign sw_cs    = sw_cs_q;
  assign ring     = ring_q;
  assign tick_1s  = tick_1s_q;

endmodule

// File: tb/tb_clock_core_ctrl.sv
// Bench for clock_core_ctrl: directed scenarios plus a randomized phase, all
// compared against a seconds/centiseconds-count reference model.
module tb_clock_core_ctrl;
  localparam int CF = 1000;
  localparam int RS = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] model, adjust_shif;
  logic       key_up, key_down, pause, clear;
  logic [4:0] time_h, alarm_h;
  logic [5:0] time_m, time_s, alarm_m, sw_m, sw_s;
  logic [6:0] sw_cs;
  logic       alarm_en, ring, tick_1s;

  logic [4:0] time_h2, alarm_h2;
  logic [5:0] time_m2, time_s2, alarm_m2, sw_m2, sw_s2;
  logic [6:0] sw_cs2;
  logic       alarm_en2, ring2, tick_1s2;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Reference state: time as seconds of day, alarm as minute of day,
  // stopwatch as total centiseconds, prescaler as edges since it last restarted.
  int m_ph, m_tod, m_amin, m_sw, m_ringcnt, n2;
  bit m_en, m_ring, m_t1s;

  always #5 clk = ~clk;

  clock_core_ctrl #(.CLK_FREQ(CF), .RING_SECS(RS), .ALARM_INIT_H(7), .ALARM_INIT_M(0)) dut (
    .clk(clk), .rst_n(rst_n), .model(model), .adjust_shif(adjust_shif),
    .key_up(key_up), .key_down(key_down), .pause(pause), .clear(clear),
    .time_h(time_h), .time_m(time_m), .time_s(time_s),
    .alarm_h(alarm_h), .alarm_m(alarm_m), .alarm_en(alarm_en),
    .sw_m(sw_m), .sw_s(sw_s), .sw_cs(sw_cs), .ring(ring), .tick_1s(tick_1s)
  );

  // Free-running stopwatch at one tick_100 per clock, exercising the long carries.
  clock_core_ctrl #(.CLK_FREQ(100), .RING_SECS(RS), .ALARM_INIT_H(7), .ALARM_INIT_M(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .model(2'b10), .adjust_shif(2'b00),
    .key_up(1'b0), .key_down(1'b0), .pause(1'b1), .clear(1'b0),
    .time_h(time_h2), .time_m(time_m2), .time_s(time_s2),
    .alarm_h(alarm_h2), .alarm_m(alarm_m2), .alarm_en(alarm_en2),
    .sw_m(sw_m2), .sw_s(sw_s2), .sw_cs(sw_cs2), .ring(ring2), .tick_1s(tick_1s2)
  );

  function automatic int wrapf(input int v, input int md, input bit up);
    return up ? (v + 1) % md : (v + md - 1) % md;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_tod = 0; m_amin = 7 * 60; m_en = 0; m_sw = 0;
    m_ring = 0; m_ringcnt = 0; m_t1s = 0; n2 = 0;
  endtask

  task automatic model_edge();
    bit adj, up, dn, any, adv, t100, hit;
    int f, h, mi, s, nt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    adj  = (model == 2'b11);
    up   = key_up && !key_down;
    dn   = key_down && !key_up;
    any  = key_up || key_down;
    adv  = m_t1s && !adj;
    t100 = !adj && (m_ph % 10 == 9);
    f    = (adjust_shif == 2'b11) ? 0 : int'(adjust_shif);
    nt   = m_tod;
    if (adv) nt = (m_tod + 1) % 86400;
    else if (adj && (up || dn)) begin
      h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
      if (f == 2) h = wrapf(h, 24, up);
      else if (f == 1) mi = wrapf(mi, 60, up);
      else s = wrapf(s, 60, up);
      nt = h * 3600 + mi * 60 + s;
    end
    hit = adv && (nt % 60 == 0) && m_en && (nt / 60 == m_amin);
    if (model == 2'b01 && (up || dn)) begin
      h = m_amin / 60; mi = m_amin % 60;
      if (f == 2) h = wrapf(h, 24, up);
      else if (f == 1) mi = wrapf(mi, 60, up);
      else m_en = up;
      m_amin = h * 60 + mi;
    end
    m_tod = nt;
    if (m_ring) begin
      if (adv) m_ringcnt++;
      if (any || !m_en || m_ringcnt >= RS) m_ring = 0;
    end else if (hit && !any) begin
      m_ring = 1;
      m_ringcnt = 0;
    end
    if (clear) m_sw = 0;
    else if (t100 && pause) m_sw = (m_sw + 1) % 360000;
    m_t1s = !adj && ((m_ph + 1) % CF == 0);
    m_ph  = adj ? 0 : m_ph + 1;
    n2++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int t2;
    t2 = (n2 >= 1) ? (n2 - 1) / 100 : 0;
    chk({tag, ".time_h"}, 32'(time_h), m_tod / 3600);
    chk({tag, ".time_m"}, 32'(time_m), (m_tod / 60) % 60);
    chk({tag, ".time_s"}, 32'(time_s), m_tod % 60);
    chk({tag, ".alarm_h"}, 32'(alarm_h), m_amin / 60);
    chk({tag, ".alarm_m"}, 32'(alarm_m), m_amin % 60);
    chk({tag, ".alarm_en"}, 32'(alarm_en), 32'(m_en));
    chk({tag, ".sw_m"}, 32'(sw_m), m_sw / 6000);
    chk({tag, ".sw_s"}, 32'(sw_s), (m_sw / 100) % 60);
    chk({tag, ".sw_cs"}, 32'(sw_cs), m_sw % 100);
    chk({tag, ".ring"}, 32'(ring), 32'(m_ring));
    chk({tag, ".tick_1s"}, 32'(tick_1s), 32'(m_t1s));
    chk({tag, ".sw2"}, {9'd0, sw_m2, sw_s2, sw_cs2, 4'd0},
        {9'd0, 6'((n2 % 360000) / 6000), 6'((n2 / 100) % 60), 7'(n2 % 100), 4'd0});
    chk({tag, ".time2"}, {15'd0, time_h2, time_m2, time_s2},
        {15'd0, 5'(t2 / 3600), 6'((t2 / 60) % 60), 6'(t2 % 60)});
    chk({tag, ".misc2"}, {20'd0, alarm_h2, alarm_m2, alarm_en2, ring2, tick_1s2, 1'b0},
        {20'd0, 5'd7, 6'd0, 1'b0, 1'b0, (n2 > 0 && n2 % 100 == 0), 1'b0});
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      key_up = 1'b0; key_down = 1'b0; clear = 1'b0;
    end
  endtask

  task automatic press(input bit up, input bit dn);
    key_up = up; key_down = dn;
    cycles(1);
  endtask

  task automatic set_field(input logic [1:0] f, input int cur, input int tgt, input int md);
    int n;
    adjust_shif = f;
    n = (tgt - cur + md) % md;
    if (n <= md / 2) repeat (n) press(1, 0);
    else repeat (md - n) press(0, 1);
  endtask

  task automatic set_time(input int h, input int mi, input int s);
    model = 2'b11;
    cycles(1);
    set_field(2'b10, m_tod / 3600, h, 24);
    set_field(2'b01, (m_tod / 60) % 60, mi, 60);
    set_field(2'b00, m_tod % 60, s, 60);
  endtask

  initial begin
    int seen, tgt;
    rst_n = 1'b0; model = 2'b00; adjust_shif = 2'b00;
    key_up = 1'b0; key_down = 1'b0; pause = 1'b0; clear = 1'b0;
    model_reset();
    cycles(3);
    check_all("reset");
    chk("reset_alarm_h", 32'(alarm_h), 7);
    rst_n = 1'b1;
    cycles(2);

    // Rollover 23:59:59 -> 00:00:00
    set_time(23, 59, 59);
    chk("preset_h", 32'(time_h), 23);
    model = 2'b00;
    cycles(CF);
    chk("first_tick", 32'(tick_1s), 1);
    chk("pre_roll_s", 32'(time_s), 59);
    cycles(1);
    chk("roll_hms", {time_h, time_m, time_s}, 0);
    check_all("rollover");

    // Adjust wrap, simultaneous keys, frozen prescaler
    model = 2'b11; adjust_shif = 2'b10;
    press(0, 1);
    chk("adj_h_wrap", 32'(time_h), 23);
    chk("adj_ms_keep", {time_m, time_s}, 0);
    press(1, 1);
    chk("adj_both_keys", 32'(time_h), 23);
    seen = 0;
    repeat (5000) begin
      cycles(1);
      if (tick_1s) seen++;
    end
    chk("adj_no_tick", seen, 0);
    check_all("adjust");

    // Alarm arm and full-length ring
    model = 2'b01; adjust_shif = 2'b00;
    press(1, 0);
    chk("alarm_en_set", 32'(alarm_en), 1);
    set_time(6, 59, 58);
    model = 2'b00;
    cycles(2 * CF + 1);
    chk("ring_rise", 32'(ring), 1);
    chk("ring_time", {time_h, time_m, time_s}, {5'd7, 6'd0, 6'd0});
    check_all("ring_start");
    cycles(29 * CF);
    chk("ring_hold29", 32'(ring), 1);
    cycles(CF);
    chk("ring_timeout", 32'(ring), 0);
    check_all("ring_end");

    // Ring cancelled by a key in clock mode
    set_time(6, 59, 58);
    model = 2'b00;
    cycles(2 * CF + 1);
    chk("ring2_rise", 32'(ring), 1);
    cycles(5 * CF);
    press(0, 1);
    chk("ring_cancel", 32'(ring), 0);
    chk("cancel_time", {time_h, time_m, time_s}, {5'd7, 6'd0, 6'd5});
    check_all("cancel");

    // Stopwatch run, hold and clear against tick_100
    model = 2'b10;
    clear = 1'b1;
    cycles(1);
    pause = 1'b1;
    cycles(1000);
    chk("sw_1s", {sw_m, sw_s, sw_cs}, {6'd0, 6'd1, 7'd0});
    pause = 1'b0;
    cycles(500);
    chk("sw_held", {sw_m, sw_s, sw_cs}, {6'd0, 6'd1, 7'd0});
    pause = 1'b1;
    cycles(37);
    for (int k = 0; k < 10 && (m_ph % 10) != 9; k++) cycles(1);
    clear = 1'b1;
    cycles(1);
    chk("sw_clear_prio", {sw_m, sw_s, sw_cs}, 0);
    check_all("stopwatch");

    // Randomized operation
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 99) < 3) model = 2'($urandom_range(0, 3));
      adjust_shif = 2'($urandom_range(0, 3));
      key_up   = ($urandom_range(0, 19) == 0);
      key_down = ($urandom_range(0, 19) == 0);
      clear    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) == 0) pause = ~pause;
      cycles(1);
      if (i % 250 == 249) check_all("random");
    end

    // Ring on the current alarm setting, then asynchronous reset mid-count
    pause = 1'b1;
    model = 2'b01; adjust_shif = 2'b00;
    press(1, 0);
    tgt = (m_amin * 60 - 1 + 86400) % 86400;
    set_time(tgt / 3600, (tgt / 60) % 60, tgt % 60);
    model = 2'b00;
    cycles(CF + 1);
    chk("final_ring", 32'(ring), 1);
    check_all("final_ring");
    cycles(13);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_ring", 32'(ring), 0);
    chk("arst_alarm", {alarm_h, alarm_m, alarm_en}, {5'd7, 6'd0, 1'b0});
    chk("arst_sw", {sw_m, sw_s, sw_cs}, 0);
    check_all("async_reset");
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    check_all("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
